// File: rtl/maxpool_bin_if.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_bin_if
//  Purpose  : Connects the conv stage to the 2x2 max-pool / binarise block.
//             The master drives conv results; the slave is the pooling block.
//  Revision : 1.0  initial release
// ============================================================================
interface maxpool_bin_if;
   logic signed [31:0] din;
   logic               ivalid;
   logic               idone;
   logic               state;
   logic signed [31:0] dout;
   logic               obin;
   logic               ovalid;
   logic               done;
   logic               frame_err;

   modport master (
      output din, ivalid, idone, state,
      input  dout, obin, ovalid, done, frame_err
   );

   modport slave (
      input  din, ivalid, idone, state,
      output dout, obin, ovalid, done, frame_err
   );
endinterface
`default_nettype wire

// File: rtl/maxpool_bin.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_bin
//  Purpose  : 2x2 stride-2 signed max pooling of a raster-ordered conv map
//             with a sign-based binarised activation. Map width follows the
//             layer latched at the first sample of each frame.
//  Revision : 1.0  initial release
// ============================================================================
module maxpool_bin #(
   parameter int K  = 5,
   parameter int N0 = 28,
   parameter int N1 = 12
) (
   input  logic          clk,
   input  logic          rstn,
   maxpool_bin_if.slave  bus
);

   localparam int W0    = N0 - K + 1;
   localparam int W1    = N1 - K + 1;
   localparam int WMAX  = (W0 > W1) ? W0 : W1;
   localparam int CW    = $clog2(WMAX);
   localparam int DEPTH = WMAX / 2;

   logic                 layer;
   logic [CW-1:0]        col;
   logic [CW-1:0]        row;
   logic [CW-1:0]        last_idx;
   logic [CW-1:0]        col_adv;
   logic [CW-1:0]        row_adv;
   logic                 abort;
   logic                 first_sample;
   logic                 last_sample;
   logic                 pool_out;
   logic                 done_due;
   logic signed [31:0]   pair;
   logic signed [31:0]   hmax;
   logic signed [31:0]   vmax;
   logic signed [31:0]   above;
   logic        [31:0]   rowbuf [0:DEPTH-1];

   // Map geometry and horizontal/vertical maxima for the current sample.
   always_comb begin
      last_idx     = layer ? CW'(W1 - 1) : CW'(W0 - 1);
      first_sample = bus.ivalid && (col == '0) && (row == '0);
      last_sample  = bus.ivalid && (col == last_idx) && (row == last_idx);
      pool_out     = bus.ivalid && row[0] && col[0];
      hmax         = (pair > bus.din) ? pair : bus.din;
      above        = $signed(rowbuf[col[CW-1:1]]);
      vmax         = (above > hmax) ? above : hmax;
   end

   // Counter advance on ivalid; a late idone then aborts a partial frame.
   // At the first sample col cannot be at the wrap point, so using the
   // previously latched layer for last_idx there is harmless.
   always_comb begin
      col_adv = col;
      row_adv = row;
      if (bus.ivalid) begin
         if (col == last_idx) begin
            col_adv = '0;
            row_adv = (row == last_idx) ? '0 : row + 1'b1;
         end else begin
            col_adv = col + 1'b1;
         end
      end
      abort = bus.idone && ((col_adv != '0) || (row_adv != '0));
   end

   // Frame position, layer latch, pair register and all registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         col           <= '0;
         row           <= '0;
         layer         <= 1'b0;
         pair          <= '0;
         bus.dout      <= '0;
         bus.obin      <= 1'b0;
         bus.ovalid    <= 1'b0;
         done_due      <= 1'b0;
         bus.done      <= 1'b0;
         bus.frame_err <= 1'b0;
      end else begin
         col           <= abort ? '0 : col_adv;
         row           <= abort ? '0 : row_adv;
         if (first_sample) begin
            layer <= bus.state;
         end
         if (bus.ivalid && !col[0]) begin
            pair <= bus.din;
         end
         bus.ovalid    <= pool_out;
         if (pool_out) begin
            bus.dout <= vmax;
            bus.obin <= ~vmax[31];
         end
         // done trails the final ovalid by one cycle, hence two stages.
         done_due      <= last_sample;
         bus.done      <= done_due;
         bus.frame_err <= abort;
      end
   end

   // Even-row horizontal maxima wait here for their odd-row partner.
   always_ff @(posedge clk) begin
      if (bus.ivalid && !row[0] && col[0]) begin
         rowbuf[col[CW-1:1]] <= hmax;
      end
   end

endmodule
`default_nettype wire

// File: doc/maxpool_bin.md
MAXPOOL_BIN -- requirements
Module: maxpool_bin

Interface
REQ-001 Parameter: K, 5, convolution kernel size; valid conv output row width is Ni-K+1.
REQ-002 Parameter: N0, 28, input map size for layer 0 (state=0), giving a 24x24 conv map and 12x12 pooled map.
REQ-003 Parameter: N1, 12, input map size for layer 1 (state=1), giving an 8x8 conv map and 4x4 pooled map.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 din  input  32  signed convolution result from the upstream conv stage.
REQ-007 ivalid  input  1  din valid; only valid-column results are flagged, W per row.
REQ-008 idone  input  1  one-cycle end-of-frame pulse from the conv stage.
REQ-009 state  input  1  layer select: 0 = first conv layer, 1 = second.
REQ-010 dout  output  32  signed 2x2 max of the pooled window.
REQ-011 obin  output  1  binarised activation: 1 if dout >= 0, else 0.
REQ-012 ovalid  output  1  dout/obin valid, one cycle per pooled pixel.
REQ-013 done  output  1  one-cycle pulse after the last pooled pixel of a frame.
REQ-014 frame_err  output  1  one-cycle pulse when idone arrives with a partial frame.

Function
REQ-015 Map width W SHALL be N0-K+1 (24) when the latched layer is 0, and N1-K+1 (8) when it is 1; the map is W x W.
REQ-016 state SHALL be latched on the first ivalid of a frame (col=0, row=0); changes mid-frame SHALL be ignored.
REQ-017 Counters col and row (0..W-1) SHALL advance only on ivalid; at col=W-1, col wraps to 0 and row increments; at row=W-1 and col=W-1, both wrap to 0.
REQ-018 On even col, din SHALL be held in a pair register; on odd col, hmax = signed max(pair register, din).
REQ-019 On even row, hmax SHALL be written to row buffer entry col/2; the buffer has W/2 entries (12 deep, 32 bits).
REQ-020 On odd row, dout SHALL register signed max(rowbuf[col/2], hmax), and ovalid SHALL assert for exactly one cycle.
REQ-021 Latency: ovalid/dout SHALL appear on the cycle after the ivalid carrying the odd-row, odd-col sample.
REQ-022 Ties SHALL yield the equal value; comparisons are 32-bit two's-complement, and no saturation is needed.
REQ-023 obin SHALL be registered alongside dout, with obin = ~dout[31].
REQ-024 Outputs per frame: 144 (state 0) or 16 (state 1), in raster order.
REQ-025 done SHALL pulse on the cycle after the final ovalid of a frame; counters are then at 0.
REQ-026 If idone arrives while (row,col) != (0,0), counters SHALL clear, frame_err SHALL pulse the next cycle, no done is issued, and row buffer contents are don't-care.
REQ-027 If idone arrives with counters at (0,0), it SHALL be ignored.
REQ-028 If idone and ivalid coincide, the ivalid sample SHALL be processed first, then the idone check applies to the updated counters.
REQ-029 Gaps in ivalid (including between rows) SHALL NOT affect results; the block has no backpressure.

Reset
REQ-030 While rstn=0: dout=0, obin=0, ovalid=0, done=0, frame_err=0; col, row, pair register and latched layer are cleared to 0.
REQ-031 Row buffer contents SHALL need no reset.
REQ-032 Reset mid-frame SHALL abort the frame silently; the next ivalid after release starts a new frame at (0,0).

Verification
REQ-033 state=1, 8x8 map with din=row*8+col, continuous ivalid: 16 outputs 9,11,13,15,25,...,63, then done one cycle after the last; obin=1 on all.
REQ-034 state=0, 24x24 map with all din=-5: 144 outputs of -5, obin=0, done once, frame_err never.
REQ-035 Window {-7,-3,-9,-2} at (0,0),(0,1),(1,0),(1,1): dout=-2, obin=0; window {0,-1,-1,-1}: dout=0, obin=1.
REQ-036 state=1, ivalid deasserted for 3 cycles after every sample: outputs match the continuous case; each ovalid follows its ivalid by 1 cycle.
REQ-037 state=1, idone after 20 samples: frame_err pulses once, no done; a following full frame produces 16 correct outputs.
REQ-038 rstn low at sample 30 of a state-0 frame: outputs are 0 during reset; a full new frame after release gives 144 correct outputs; state toggled mid-frame has no effect.
